// File: rtl/rr_select_arbiter.sv
// Four-requester round-robin arbiter producing a registered 2-bit select code for a decoder stage.
// A grant is held until done, request drop, or MAX_HOLD timeout; one idle bubble always separates grants.
module rr_select_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] req_i,
    input  logic       done_i,
    output logic       gnt_valid_o,
    output logic [1:0] gnt_idx_o,
    output logic       expired_o
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HCNT_ONE   = HW'(1);
    localparam logic [HW-1:0] HCNT_ZERO  = HW'(0);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic            valid_q, valid_d;
    logic [1:0]      idx_q, idx_d;
    logic            exp_q, exp_d;

    logic [1:0]      winner_s;
    logic [1:0]      cand_s;
    logic            found_s;
    logic            owner_req_s;
    logic            timeout_s;
    logic            release_s;

    assign owner_req_s = req_i[idx_q];
    assign timeout_s   = (hcnt_q == HOLD_LIMIT);
    assign release_s   = done_i || !owner_req_s || timeout_s;

    // Rotating priority search: first set request at or after ptr, modulo 4.
    always_comb begin
        winner_s = ptr_q;
        found_s  = 1'b0;
        cand_s   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand_s = ptr_q + 2'(k);
            if (!found_s && req_i[cand_s]) begin
                winner_s = cand_s;
                found_s  = 1'b1;
            end else begin
                winner_s = winner_s;
                found_s  = found_s;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/GRANT machine.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hcnt_d  = hcnt_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        exp_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    state_d = S_GRANT;
                    valid_d = 1'b1;
                    idx_d   = winner_s;
                    hcnt_d  = HCNT_ONE;
                end else begin
                    valid_d = 1'b0;
                end
            end
            S_GRANT: begin
                if (release_s) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    ptr_d   = idx_q + 2'd1;
                    hcnt_d  = HCNT_ZERO;
                    // Only a pure timeout flags expiry; done or a request drop take precedence.
                    exp_d   = !done_i && owner_req_s && timeout_s;
                end else begin
                    hcnt_d  = hcnt_q + HCNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                hcnt_d  = HCNT_ZERO;
            end
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            hcnt_q  <= HCNT_ZERO;
            valid_q <= 1'b0;
            idx_q   <= 2'd0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            exp_q   <= exp_d;
        end
    end

    assign gnt_valid_o = valid_q;
    assign gnt_idx_o   = idx_q;
    assign expired_o   = exp_q;

endmodule

// File: doc/rr_select_arbiter.md
# rr_select_arbiter

Four-requester round-robin arbiter that produces the 2-bit select code consumed by the downstream `decoder2to4` stage. The block turns one-hot `req` lines into `gnt_idx`/`gnt_valid`, which feed the decoder's `S` and gate its one-hot `I` enables. A grant is held until the owner signals `done`, drops its request, or hits a hold-time limit. Priority then rotates.

## Interface
- `MAX_HOLD`, 8, maximum consecutive cycles one grant may be held; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  request lines; `req[i]` = requester i wants the shared resource.
- `done`  in  1  single-cycle release pulse from the current owner; ignored when no grant is active.
- `gnt_valid`  out  1  a grant is active; qualifies `gnt_idx`.
- `gnt_idx`  out  2  index of the granted requester; drives the decoder `S`.
- `expired`  out  1  one-cycle pulse: the last grant was revoked by the `MAX_HOLD` timeout.

## Operation
- Two states: IDLE and GRANT. All outputs are registered.
- Internal state:
  - rotating pointer `ptr` (2 bits): the highest-priority requester.
  - hold counter `hcnt`, width clog2(MAX_HOLD+1).
- **IDLE with `req` != 0 at an edge:**
  - Search from `ptr` upward, modulo 4; the first set bit wins.
  - Next cycle: `gnt_valid`=1, `gnt_idx`=winner, `hcnt`=1, state GRANT.
- **IDLE with `req` == 0:** remain in IDLE; `gnt_valid`=0; `gnt_idx` holds its last value.
- **GRANT release conditions**, evaluated at each edge in priority order:
  - `done`=1.
  - `req[gnt_idx]`=0.
  - `hcnt`==MAX_HOLD.
- **On release:**
  - Next cycle: `gnt_valid`=0, state IDLE, `ptr`=`gnt_idx`+1 mod 4.
  - `expired`=1 only if the timeout was the sole cause.
- **GRANT with no release:** `hcnt` increments and the grant is unchanged.
- The grant is never reassigned directly from GRANT to GRANT. One bubble cycle with `gnt_valid`=0 always separates grants, so the decoder never sees a mid-cycle select change.
- **Simultaneous events:**
  - `done` together with the timeout is treated as `done`; `expired`=0.
  - `done` together with the owner's request drop is treated as a normal release.
- New requests arriving during GRANT do not preempt; they are arbitrated in the next IDLE cycle.

## Timing
- Reset values:
  - `gnt_valid`=0, `gnt_idx`=0, `expired`=0.
  - `ptr`=0, `hcnt`=0, state IDLE.
- Reset mid-grant clears everything at the next edge.
- Request-to-grant latency: `req` sampled at edge k gives `gnt_valid`=1 after edge k.
- Release latency: a release condition sampled at edge k gives `gnt_valid`=0 after edge k.
- Grant-to-grant gap, with continuous demand: exactly 1 cycle with `gnt_valid`=0.
- Timeout: with no other release, `gnt_valid` is high for exactly MAX_HOLD cycles. `expired` is high in the first `gnt_valid`=0 cycle that follows.
- `expired` is high for exactly one cycle per timeout; it is otherwise 0.
- Fairness: with all four requesters continuously requesting, each is granted within 4 grants.

## Test plan
1. **Reset:** hold `rst`=1 for 2 cycles with `req`=4'b1111.
   - Required: `gnt_valid`=0, `gnt_idx`=0, `expired`=0 throughout.
   - After release with `req`=4'b1111: first grant is `gnt_idx`=0.
2. **Single requester with `done`:** `req`=4'b0100 held; `done` pulsed on the 3rd grant cycle.
   - Grant (`gnt_idx`=2) appears 1 cycle after `req` is sampled and lasts 3 cycles.
   - Then 1 bubble cycle, then `gnt_idx`=2 is regranted.
3. **Rotation:** `req`=4'b1111; `done` pulsed on each grant's first cycle.
   - `gnt_idx` sequence: 0,1,2,3,0, with `gnt_valid` alternating 1,0.
4. **Timeout:** MAX_HOLD=8, `req`=4'b1010, no `done`.
   - `gnt_idx`=1 is held for 8 cycles, then `expired`=1 for one cycle.
   - Next grant is `gnt_idx`=3.
   - Repeat with `done` asserted on the 8th grant cycle: `expired` stays 0.
5. **Request drop:** `req[0]` is granted, then deasserted on the 2nd grant cycle.
   - `gnt_valid`=0 on the next cycle; `expired`=0; `ptr` moves to 1.
6. **Reset mid-grant:** `req`=4'b1111; assert `rst` while `gnt_idx`=2 is active.
   - Outputs clear on the next edge.
   - After reset deasserts, the first grant is `gnt_idx`=0.
